carregador_vetores: RTL and testbench
=====================================

# carregador_vetores

Serial-to-parallel loader that sits directly upstream of the vector-operator stage (bitwise OR, logical OR, inversion). It assembles two `LARGURA`-bit operands, `a` then `b`, from a serial bit stream. It then presents both together with a valid/ready handshake. Outputs are registered and hold stable between frames, so the combinational operator stage can consume them directly. A per-frame idle timeout discards stalled frames.

## Interface
- `LARGURA`, 3, width of each operand (≥1)
- `TIMEOUT`, 15, consecutive idle cycles tolerated inside a frame before abort (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `inicio`  in  1  start-of-frame strobe
- `bit_serial`  in  1  serial data, LSB first, `a` bits then `b` bits
- `bit_valido`  in  1  `bit_serial` valid this cycle
- `a`  out  LARGURA  delivered operand A (registered)
- `b`  out  LARGURA  delivered operand B (registered)
- `saida_valida`  out  1  `a`/`b` hold a new, unconsumed pair
- `saida_pronta`  in  1  downstream accepts pair
- `ocupado`  out  1  frame in progress or awaiting handshake
- `erro_timeout`  out  1  one-cycle pulse on frame abort

## Operation
- FSM states: `OCIOSO`, `RECEBE_A`, `RECEBE_B`, `ENTREGA`.
- **`OCIOSO`:**
  - `inicio=1` clears the shadow registers, bit counter and idle counter, then moves to `RECEBE_A`.
  - `bit_valido` is ignored, including in the same cycle as `inicio`.
- **`RECEBE_A`:**
  - Each `bit_valido` writes `bit_serial` into shadow A at index = bit counter, then increments the counter.
  - After the `LARGURA`-th bit, the counter clears and the FSM moves to `RECEBE_B`.
- **`RECEBE_B`:** same as `RECEBE_A` for shadow B. After the `LARGURA`-th bit:
  - `a` and `b` load from the shadows in the same edge.
  - `saida_valida` goes high and the FSM moves to `ENTREGA`.
- **`ENTREGA`:**
  - `saida_valida` is held high until `saida_valida && saida_pronta`; the FSM then returns to `OCIOSO`.
  - `inicio` and `bit_valido` are ignored.
- **Priority in `RECEBE_*`:**
  - `inicio` beats `bit_valido`: the frame restarts at `RECEBE_A` bit 0, the shadows clear, and the bit is discarded.
  - Timeout is checked only when neither `inicio` nor `bit_valido` is high.
- **Idle counter:**
  - Increments each `RECEBE_*` cycle without `bit_valido`, and resets on `bit_valido`.
  - On reaching `TIMEOUT`: `erro_timeout` pulses, the FSM goes to `OCIOSO`, the shadows are discarded, and `a`/`b`/`saida_valida` are unchanged.
- `a`/`b` change only on a completed frame and otherwise keep the last delivered pair.
- `ocupado` = state ≠ `OCIOSO`.
- **Reset (any time, including mid-frame or mid-handshake):**
  - State goes to `OCIOSO`.
  - `a`=0, `b`=0, `saida_valida`=0, `ocupado`=0, `erro_timeout`=0; shadows and counters are 0.
- **Widths:**
  - Bit counter: `$clog2(LARGURA+1)` bits.
  - Idle counter: `$clog2(TIMEOUT+1)` bits, which saturates and cannot wrap.

## Timing
- **Minimum frame:**
  - `inicio` at cycle 0, bits at cycles 1…2·`LARGURA`.
  - `saida_valida` high at cycle 2·`LARGURA`+1 (cycle 7 for `LARGURA`=3).
- **Bit-to-output latency:** 1 cycle after the last `b` bit edge.
- **Handshake:** the transfer completes in the cycle both are high. `saida_valida` is low the next cycle and a new `inicio` is accepted that same cycle. Back-to-back frames with `saida_pronta` held at 1 therefore take 2·`LARGURA`+2 cycles.
- **Back-pressure:** `saida_pronta` low holds `ENTREGA` indefinitely; no timeout applies in `ENTREGA`.
- **Timeout:** `erro_timeout` is high for exactly one cycle, the cycle after the `TIMEOUT`-th consecutive idle cycle. `ocupado` is low in that same cycle.
- All outputs come straight from registers; there are no combinational input-to-output paths.

## Structure
- **Shared package `pacote_vetores`:**
  - `estado_carga_t` enum (the four states).
  - Default `LARGURA_VETOR = 3`, shared with the operator stage.
- **Sub-module `contador_timeout`:**
  - Parameter `TIMEOUT`.
  - Inputs `clk`, `rst_n`, `limpa`, `conta`.
  - Output `expirou`.
  - Saturating counter.
- The top level holds the FSM, the shadow registers and the output registers.

## Test plan
- **Basic frame:** reset, `inicio`, then bits 1,0,1 then 0,1,0 on consecutive cycles → `a`=3'b101, `b`=3'b010, `saida_valida` at cycle 7, `ocupado` high for cycles 1–7.
- **Back-pressure:** same frame with `saida_pronta`=0 for 5 cycles → `saida_valida` held, `a`/`b` stable. Raise `saida_pronta` → `saida_valida` low next cycle. A new frame with bits 1,1,1,0,0,1 → `a`=3'b111, `b`=3'b100.
- **Restart:** `inicio` after 4 bits, with `bit_valido` also high that cycle → that bit is discarded. The frame then completes from bit 0 with bits 0,1,1,1,0,0 → `a`=3'b110, `b`=3'b001.
- **Timeout:** `TIMEOUT`=15, `inicio`, 2 bits, then 15 idle cycles → one-cycle `erro_timeout`, `ocupado` low, `a`/`b` keep the previous pair, `saida_valida` stays 0.
- **Ignored inputs:** `bit_valido` pulses in `OCIOSO`, and `inicio` in `ENTREGA` → no state change, no corruption of `a`/`b`.
- **Async reset mid-frame:** assert `rst_n`=0 between clock edges during `RECEBE_B` → all outputs 0 immediately. Release reset, then run a clean frame → correct pair.

Source files
------------

// File: rtl/carregador_vetores_pkg.sv
// rtl/carregador_vetores_pkg.sv - shared types and defaults for the vector loader and operator stage
package pacote_vetores;

  // Operand width shared with the downstream vector-operator stage
  localparam int LARGURA_VETOR = 3;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    RECEBE_A = 2'd1,
    RECEBE_B = 2'd2,
    ENTREGA  = 2'd3
  } estado_carga_t;

endpackage

// File: rtl/carregador_vetores_if.sv
// rtl/carregador_vetores_if.sv - serial input and parallel output bundle of the vector loader
import pacote_vetores::*;

interface carregador_vetores_if #(
  parameter int LARGURA = LARGURA_VETOR
);
  logic               inicio;
  logic               bit_serial;
  logic               bit_valido;
  logic               saida_pronta;
  logic [LARGURA-1:0] a;
  logic [LARGURA-1:0] b;
  logic               saida_valida;
  logic               ocupado;
  logic               erro_timeout;

  // Side that feeds bits and consumes the operand pair
  modport master (
    output inicio, bit_serial, bit_valido, saida_pronta,
    input  a, b, saida_valida, ocupado, erro_timeout
  );

  // The loader itself
  modport slave (
    input  inicio, bit_serial, bit_valido, saida_pronta,
    output a, b, saida_valida, ocupado, erro_timeout
  );
endinterface

// File: rtl/carregador_vetores_contador_timeout.sv
// rtl/carregador_vetores_contador_timeout.sv - saturating idle counter that flags a stalled frame
module contador_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpa,
  input  logic conta,
  output logic expirou
);
  localparam int            W      = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  MAXIMO = W'(TIMEOUT);
  localparam logic [W-1:0]  LIMITE = W'(TIMEOUT - 1);

  logic [W-1:0] contagem;

  // Count consecutive idle cycles, clearing on request and holding at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (conta && (contagem != MAXIMO)) begin
      contagem <= contagem + 1'b1;
    end
  end

  // High while the current idle cycle is the TIMEOUT-th in a row, so the
  // owner can register its abort on this same edge
  assign expirou = conta && (contagem >= LIMITE);

endmodule

// File: rtl/carregador_vetores.sv
// rtl/carregador_vetores.sv - serial-to-parallel loader for the two vector operands
module carregador_vetores
  import pacote_vetores::*;
#(
  parameter int LARGURA = LARGURA_VETOR,
  parameter int TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  carregador_vetores_if.slave porta
);
  localparam int              CW     = $clog2(LARGURA + 1);
  localparam logic [CW-1:0]   ULTIMO = CW'(LARGURA - 1);

  estado_carga_t      estado, estado_prox;
  logic [LARGURA-1:0] sombra_a, sombra_a_prox;
  logic [LARGURA-1:0] sombra_b, sombra_b_prox;
  logic [CW-1:0]      cont_bits, cont_bits_prox;
  logic [LARGURA-1:0] a_reg, a_prox;
  logic [LARGURA-1:0] b_reg, b_prox;
  logic               valida_reg, valida_prox;
  logic               erro_reg, erro_prox;
  logic               ocupado_reg;
  logic               recebendo;
  logic               limpa_ocioso;
  logic               conta_ocioso;
  logic               expirou;

  assign recebendo    = (estado == RECEBE_A) || (estado == RECEBE_B);
  // Idle time only accrues inside a frame and only when nothing else happened
  assign limpa_ocioso = !recebendo || porta.inicio || porta.bit_valido;
  assign conta_ocioso = recebendo && !porta.inicio && !porta.bit_valido;

  contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_contador_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .limpa   (limpa_ocioso),
    .conta   (conta_ocioso),
    .expirou (expirou)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next state, shadow capture and output-pair updates
  always_comb begin
    estado_prox    = estado;
    sombra_a_prox  = sombra_a;
    sombra_b_prox  = sombra_b;
    cont_bits_prox = cont_bits;
    a_prox         = a_reg;
    b_prox         = b_reg;
    valida_prox    = valida_reg;
    erro_prox      = 1'b0;

    case (estado)
      OCIOSO: begin
        if (porta.inicio) begin
          estado_prox    = RECEBE_A;
          sombra_a_prox  = '0;
          sombra_b_prox  = '0;
          cont_bits_prox = '0;
        end
      end

      RECEBE_A, RECEBE_B: begin
        if (porta.inicio) begin
          // Restart wins over a coincident bit, which is dropped
          estado_prox    = RECEBE_A;
          sombra_a_prox  = '0;
          sombra_b_prox  = '0;
          cont_bits_prox = '0;
        end else if (porta.bit_valido) begin
          for (int i = 0; i < LARGURA; i++) begin
            if (cont_bits == CW'(i)) begin
              if (estado == RECEBE_A) begin
                sombra_a_prox[i] = porta.bit_serial;
              end else begin
                sombra_b_prox[i] = porta.bit_serial;
              end
            end
          end
          if (cont_bits == ULTIMO) begin
            cont_bits_prox = '0;
            if (estado == RECEBE_A) begin
              estado_prox = RECEBE_B;
            end else begin
              // Last b bit lands in the output pair on the same edge
              estado_prox = ENTREGA;
              a_prox      = sombra_a_prox;
              b_prox      = sombra_b_prox;
              valida_prox = 1'b1;
            end
          end else begin
            cont_bits_prox = cont_bits + 1'b1;
          end
        end else if (expirou) begin
          // Stalled frame: drop partial data, keep the last delivered pair
          estado_prox    = OCIOSO;
          sombra_a_prox  = '0;
          sombra_b_prox  = '0;
          cont_bits_prox = '0;
          erro_prox      = 1'b1;
        end
      end

      ENTREGA: begin
        if (porta.saida_pronta) begin
          estado_prox = OCIOSO;
          valida_prox = 1'b0;
        end
      end

      default: begin
        estado_prox = OCIOSO;
      end
    endcase
  end

  // Shadow, counter and output registers; outputs never see inputs combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sombra_a    <= '0;
      sombra_b    <= '0;
      cont_bits   <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      valida_reg  <= 1'b0;
      erro_reg    <= 1'b0;
      ocupado_reg <= 1'b0;
    end else begin
      sombra_a    <= sombra_a_prox;
      sombra_b    <= sombra_b_prox;
      cont_bits   <= cont_bits_prox;
      a_reg       <= a_prox;
      b_reg       <= b_prox;
      valida_reg  <= valida_prox;
      erro_reg    <= erro_prox;
      ocupado_reg <= (estado_prox != OCIOSO);
    end
  end

  assign porta.a            = a_reg;
  assign porta.b            = b_reg;
  assign porta.saida_valida = valida_reg;
  assign porta.erro_timeout = erro_reg;
  assign porta.ocupado      = ocupado_reg;

endmodule

// File: tb/tb_carregador_vetores.sv
// tb/tb_carregador_vetores.sv - directed and randomized self-checking bench for carregador_vetores
module tb_carregador_vetores;
  import pacote_vetores::*;

  localparam int L = 3;
  localparam int T = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  carregador_vetores_if #(.LARGURA(L)) vif ();

  carregador_vetores #(
    .LARGURA (L),
    .TIMEOUT (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .porta (vif)
  );

  always #5 clk = ~clk;

  int n_comp  = 0;
  int n_falha = 0;
  int ciclo   = 0;

  // Frame-level reference: collected bits, delivery flag, idle run length
  bit         m_quadro;
  bit         m_entrega;
  bit         m_erro;
  bit         fila[$];
  int         m_ocioso;
  logic [L-1:0] m_a;
  logic [L-1:0] m_b;

  task automatic compara(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    assert (obs === esp) else begin
      n_falha++;
      $error("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  task automatic modelo_reset();
    m_quadro  = 0;
    m_entrega = 0;
    m_erro    = 0;
    fila.delete();
    m_ocioso  = 0;
    m_a       = '0;
    m_b       = '0;
  endtask

  task automatic modelo_passo(input bit ini, input bit bv, input bit bs, input bit pr);
    m_erro = 0;
    if (m_entrega) begin
      if (pr) m_entrega = 0;
    end else if (m_quadro) begin
      if (ini) begin
        fila.delete();
        m_ocioso = 0;
      end else if (bv) begin
        fila.push_back(bs);
        m_ocioso = 0;
        if (fila.size() == 2 * L) begin
          for (int i = 0; i < L; i++) begin
            m_a[i] = fila[i];
            m_b[i] = fila[L + i];
          end
          m_entrega = 1;
          m_quadro  = 0;
          fila.delete();
        end
      end else begin
        m_ocioso++;
        if (m_ocioso == T) begin
          m_erro   = 1;
          m_quadro = 0;
          fila.delete();
        end
      end
    end else if (ini) begin
      m_quadro = 1;
      fila.delete();
      m_ocioso = 0;
    end
  endtask

  task automatic confere_modelo();
    string c;
    c = $sformatf("ciclo%0d", ciclo);
    compara({c, "/a"}, 32'(vif.a), 32'(m_a));
    compara({c, "/b"}, 32'(vif.b), 32'(m_b));
    compara({c, "/saida_valida"}, 32'(vif.saida_valida), 32'(m_entrega));
    compara({c, "/ocupado"}, 32'(m_quadro || m_entrega) ^ 32'(vif.ocupado) ^ 32'(m_quadro || m_entrega), 32'(m_quadro || m_entrega));
    compara({c, "/erro_timeout"}, 32'(vif.erro_timeout), 32'(m_erro));
  endtask

  task automatic passo(input bit ini, input bit bv, input bit bs, input bit pr);
    vif.inicio       = ini;
    vif.bit_valido   = bv;
    vif.bit_serial   = bs;
    vif.saida_pronta = pr;
    @(posedge clk);
    ciclo++;
    modelo_passo(ini, bv, bs, pr);
    #1;
    confere_modelo();
  endtask

  task automatic quadro(input logic [L-1:0] va, input logic [L-1:0] vb);
    passo(1, 0, 0, 0);
    for (int i = 0; i < L; i++) passo(0, 1, va[i], 0);
    for (int i = 0; i < L; i++) passo(0, 1, vb[i], 0);
  endtask

  task automatic confere_zero(input string tag);
    compara({tag, "/a"}, 32'(vif.a), 32'd0);
    compara({tag, "/b"}, 32'(vif.b), 32'd0);
    compara({tag, "/saida_valida"}, 32'(vif.saida_valida), 32'd0);
    compara({tag, "/ocupado"}, 32'(vif.ocupado), 32'd0);
    compara({tag, "/erro_timeout"}, 32'(vif.erro_timeout), 32'd0);
  endtask

  int prob[4] = '{70, 90, 5, 50};

  initial begin
    vif.inicio       = 0;
    vif.bit_valido   = 0;
    vif.bit_serial   = 0;
    vif.saida_pronta = 0;
    modelo_reset();

    // Reset state
    #3;
    confere_zero("reset");
    #10;
    rst_n = 1'b1;

    // Basic frame: a bits 1,0,1 and b bits 0,1,0, LSB first
    quadro(3'b101, 3'b010);
    compara("basico/saida_valida", 32'(vif.saida_valida), 32'd1);
    compara("basico/a", 32'(vif.a), 32'h5);
    compara("basico/b", 32'(vif.b), 32'h2);
    compara("basico/ocupado", 32'(vif.ocupado), 32'd1);
    passo(0, 0, 0, 1);
    compara("basico_aceite/saida_valida", 32'(vif.saida_valida), 32'd0);
    compara("basico_aceite/ocupado", 32'(vif.ocupado), 32'd0);

    // Back-pressure holds the pair and the valid flag
    quadro(3'b101, 3'b010);
    repeat (5) passo(0, 0, 0, 0);
    compara("pressao/saida_valida", 32'(vif.saida_valida), 32'd1);
    compara("pressao/a", 32'(vif.a), 32'h5);
    compara("pressao/b", 32'(vif.b), 32'h2);
    passo(0, 0, 0, 1);
    compara("pressao_aceite/saida_valida", 32'(vif.saida_valida), 32'd0);
    quadro(3'b111, 3'b100);
    compara("pressao2/a", 32'(vif.a), 32'h7);
    compara("pressao2/b", 32'(vif.b), 32'h4);
    passo(0, 0, 0, 1);

    // Ignored inputs: bits while idle, start strobes while delivering
    repeat (3) passo(0, 1, 1, 0);
    compara("ignora_ocioso/ocupado", 32'(vif.ocupado), 32'd0);
    compara("ignora_ocioso/a", 32'(vif.a), 32'h7);
    quadro(3'b010, 3'b011);
    repeat (2) passo(1, 1, 1, 0);
    compara("ignora_entrega/a", 32'(vif.a), 32'h2);
    compara("ignora_entrega/b", 32'(vif.b), 32'h3);
    compara("ignora_entrega/saida_valida", 32'(vif.saida_valida), 32'd1);
    passo(0, 0, 0, 1);

    // Restart mid-frame with a coincident bit that must be dropped
    passo(1, 0, 0, 0);
    repeat (4) passo(0, 1, 1, 0);
    passo(1, 1, 1, 0);
    passo(0, 1, 0, 0);
    passo(0, 1, 1, 0);
    passo(0, 1, 1, 0);
    passo(0, 1, 1, 0);
    passo(0, 1, 0, 0);
    passo(0, 1, 0, 0);
    compara("reinicio/a", 32'(vif.a), 32'h6);
    compara("reinicio/b", 32'(vif.b), 32'h1);
    compara("reinicio/saida_valida", 32'(vif.saida_valida), 32'd1);
    passo(0, 0, 0, 1);

    // Timeout after two bits and T idle cycles
    passo(1, 0, 0, 0);
    passo(0, 1, 1, 0);
    passo(0, 1, 0, 0);
    repeat (T - 1) passo(0, 0, 0, 0);
    compara("timeout_antes/erro_timeout", 32'(vif.erro_timeout), 32'd0);
    compara("timeout_antes/ocupado", 32'(vif.ocupado), 32'd1);
    passo(0, 0, 0, 0);
    compara("timeout/erro_timeout", 32'(vif.erro_timeout), 32'd1);
    compara("timeout/ocupado", 32'(vif.ocupado), 32'd0);
    compara("timeout/saida_valida", 32'(vif.saida_valida), 32'd0);
    compara("timeout/a", 32'(vif.a), 32'h6);
    compara("timeout/b", 32'(vif.b), 32'h1);
    passo(0, 0, 0, 0);
    compara("timeout_pulso/erro_timeout", 32'(vif.erro_timeout), 32'd0);

    // Asynchronous reset between edges while receiving b
    passo(1, 0, 0, 0);
    repeat (L + 1) passo(0, 1, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    confere_zero("reset_async");
    modelo_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    quadro(3'b011, 3'b101);
    compara("pos_reset/a", 32'(vif.a), 32'h3);
    compara("pos_reset/b", 32'(vif.b), 32'h5);
    passo(0, 0, 0, 1);

    // Randomized traffic with varying bit density to reach restarts and timeouts
    for (int f = 0; f < 4; f++) begin
      repeat (150) begin
        passo(($urandom_range(0, 15) == 0),
              ($urandom_range(0, 99) < prob[f]),
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 2) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
    $finish;
  end

endmodule
